// File: rtl/wshb_mire_if.sv
// Wishbone classic bus bundle shared by the test-pattern master and the memory slave.
interface wshb_if (
    input logic clk,
    input logic rst
);
    logic        cyc;
    logic        stb;
    logic        we;
    logic [31:0] adr;
    logic [31:0] dat_ms;
    logic [31:0] dat_sm;
    logic [3:0]  sel;
    logic [2:0]  cti;
    logic [1:0]  bte;
    logic        ack;

    modport master (
        input  clk, rst, ack, dat_sm,
        output cyc, stb, we, adr, dat_ms, sel, cti, bte
    );

    modport slave (
        input  clk, rst, cyc, stb, we, adr, dat_ms, sel, cti, bte,
        output ack, dat_sm
    );
endinterface

// File: rtl/wshb_mire.sv
// Test-pattern writer: fills the frame buffer with a 16-pixel white grid, frame after frame.
// Define MIRE_YIELD_EN to drop the bus for one cycle after every BURST acknowledged writes.
module wshb_mire #(
    parameter int unsigned HDISP = 800,
    parameter int unsigned VDISP = 480,
    parameter int unsigned BURST = 64
) (
    wshb_if.master wshb_ifm,
    output logic   frame_done
);
    localparam int unsigned NPIX = HDISP * VDISP;
    localparam int unsigned AW   = $clog2(NPIX);
    localparam int unsigned XW   = ($clog2(HDISP) < 4) ? 4 : $clog2(HDISP);
    localparam int unsigned YW   = ($clog2(VDISP) < 4) ? 4 : $clog2(VDISP);

    logic [XW-1:0] x_q, x_d;
    logic [YW-1:0] y_q, y_d;
    logic [AW-1:0] widx_q, widx_d;
    logic          frame_done_q, frame_done_d;
    logic          cyc;
    logic          ack_ok;
    logic          last_x;
    logic          last_y;

`ifdef MIRE_YIELD_EN
    typedef enum logic {WRITE, PAUSE} state_t;
    localparam int unsigned BW = (BURST > 1) ? $clog2(BURST) : 1;

    state_t        state_q, state_d;
    logic [BW-1:0] burst_q, burst_d;

    assign cyc = ~wshb_ifm.rst & (state_q == WRITE);
`else
    assign cyc = ~wshb_ifm.rst;
`endif

    assign ack_ok = cyc & wshb_ifm.ack;
    assign last_x = (x_q == XW'(HDISP - 1));
    assign last_y = (y_q == YW'(VDISP - 1));

    always_comb begin
        x_d          = x_q;
        y_d          = y_q;
        widx_d       = widx_q;
        frame_done_d = 1'b0;
        if (ack_ok) begin
            if (last_x) begin
                x_d = '0;
                if (last_y) begin
                    y_d          = '0;
                    widx_d       = '0;
                    frame_done_d = 1'b1;
                end else begin
                    y_d    = y_q + 1'b1;
                    widx_d = widx_q + 1'b1;
                end
            end else begin
                x_d    = x_q + 1'b1;
                widx_d = widx_q + 1'b1;
            end
        end
    end

    always_ff @(posedge wshb_ifm.clk or posedge wshb_ifm.rst) begin
        if (wshb_ifm.rst) begin
            x_q          <= '0;
            y_q          <= '0;
            widx_q       <= '0;
            frame_done_q <= 1'b0;
        end else begin
            x_q          <= x_d;
            y_q          <= y_d;
            widx_q       <= widx_d;
            frame_done_q <= frame_done_d;
        end
    end

`ifdef MIRE_YIELD_EN
    // A burst end wins over the frame-wrap clear so the yield still happens on the last pixel.
    always_comb begin
        state_d = state_q;
        burst_d = burst_q;
        case (state_q)
            WRITE: begin
                if (ack_ok) begin
                    if (burst_q == BW'(BURST - 1)) begin
                        burst_d = '0;
                        state_d = PAUSE;
                    end else if (frame_done_d) begin
                        burst_d = '0;
                    end else begin
                        burst_d = burst_q + 1'b1;
                    end
                end
            end
            PAUSE:   state_d = WRITE;
            default: state_d = WRITE;
        endcase
    end

    always_ff @(posedge wshb_ifm.clk or posedge wshb_ifm.rst) begin
        if (wshb_ifm.rst) begin
            state_q <= WRITE;
            burst_q <= '0;
        end else begin
            state_q <= state_d;
            burst_q <= burst_d;
        end
    end
`endif

    assign wshb_ifm.cyc    = cyc;
    assign wshb_ifm.stb    = cyc;
    assign wshb_ifm.we     = 1'b1;
    assign wshb_ifm.adr    = 32'({widx_q, 2'b00});
    assign wshb_ifm.dat_ms = ((x_q[3:0] == 4'd0) || (y_q[3:0] == 4'd0)) ? 32'h00FF_FFFF : '0;
    assign wshb_ifm.sel    = 4'b1111;
    assign wshb_ifm.cti    = 3'b000;
    assign wshb_ifm.bte    = 2'b00;
    assign frame_done      = frame_done_q;
endmodule

// File: tb/tb_wshb_mire.sv
// Bench for wshb_mire: a full-size instance and a small one (fast frame wrap), both checked
// every cycle against a word-count model of the pattern writer.
`timescale 1ns/1ps
module tb_wshb_mire;
    localparam int HA = 800, VA = 480, BA = 64;
    localparam int HB = 20,  VB = 18,  BB = 8;
`ifdef MIRE_YIELD_EN
    localparam bit YIELD = 1'b1;
`else
    localparam bit YIELD = 1'b0;
`endif

    logic clk   = 1'b0;
    logic rst_a = 1'b1;
    logic rst_b = 1'b1;
    logic fd_a, fd_b;
    int   n_vec = 0;
    int   n_err = 0;

    always #5 clk = ~clk;

    wshb_if ifa (.clk(clk), .rst(rst_a));
    wshb_if ifb (.clk(clk), .rst(rst_b));

    wshb_mire #(.HDISP(HA), .VDISP(VA), .BURST(BA)) dut_a (.wshb_ifm(ifa), .frame_done(fd_a));
    wshb_mire #(.HDISP(HB), .VDISP(VB), .BURST(BB)) dut_b (.wshb_ifm(ifb), .frame_done(fd_b));

    // Model: next word to write, pending pause cycle, frame_done expected this cycle.
    int m_word[2];
    bit m_pause[2];
    bit m_fd[2];
    int m_h[2] = '{HA, HB};
    int m_n[2] = '{HA * VA, HB * VB};
    int m_b[2] = '{BA, BB};

    function automatic logic [31:0] grid(input int w, input int h);
        int x, y;
        x = w % h;
        y = w / h;
        return (((x % 16) == 0) || ((y % 16) == 0)) ? 32'h00FF_FFFF : 32'h0000_0000;
    endfunction

    // One clock for both instances; compares every output against the model, then advances it.
    task automatic cycle(input logic a0, input logic a1);
        logic r[2], c[2], s[2], f[2], a[2];
        logic [31:0] ad[2], dt[2];
        logic ec, ef;
        #1;
        r[0] = rst_a;   r[1] = rst_b;
        c[0] = ifa.cyc; c[1] = ifb.cyc;
        s[0] = ifa.stb; s[1] = ifb.stb;
        f[0] = fd_a;    f[1] = fd_b;
        ad[0] = ifa.adr;    ad[1] = ifb.adr;
        dt[0] = ifa.dat_ms; dt[1] = ifb.dat_ms;
        a[0] = a0; a[1] = a1;
        for (int i = 0; i < 2; i++) begin
            ec = !r[i] && !m_pause[i];
            ef = !r[i] && m_fd[i];
            n_vec++;
            if (c[i] !== ec) begin
                n_err++;
                $display("FAIL cyc[%0d] t=%0t got %b want %b (word %0d)", i, $time, c[i], ec, m_word[i]);
            end
            n_vec++;
            if (s[i] !== ec) begin
                n_err++;
                $display("FAIL stb[%0d] t=%0t got %b want %b", i, $time, s[i], ec);
            end
            n_vec++;
            if (f[i] !== ef) begin
                n_err++;
                $display("FAIL frame_done[%0d] t=%0t got %b want %b (word %0d)", i, $time, f[i], ef, m_word[i]);
            end
            if (ec) begin
                n_vec++;
                if (ad[i] !== 32'(m_word[i] * 4)) begin
                    n_err++;
                    $display("FAIL adr[%0d] t=%0t got %h want %h", i, $time, ad[i], 32'(m_word[i] * 4));
                end
                n_vec++;
                if (dt[i] !== grid(m_word[i], m_h[i])) begin
                    n_err++;
                    $display("FAIL dat[%0d] t=%0t got %h want %h (word %0d)", i, $time, dt[i], grid(m_word[i], m_h[i]), m_word[i]);
                end
            end
        end
        ifa.ack = a0;
        ifb.ack = a1;
        @(posedge clk);
        for (int i = 0; i < 2; i++) begin
            if (r[i]) begin
                m_word[i] = 0; m_pause[i] = 0; m_fd[i] = 0;
            end else begin
                m_fd[i] = 0;
                if (m_pause[i]) m_pause[i] = 0;
                else if (a[i]) begin
                    if (YIELD && (((m_word[i] + 1) % m_b[i]) == 0)) m_pause[i] = 1;
                    if (m_word[i] == m_n[i] - 1) begin
                        m_word[i] = 0;
                        m_fd[i]   = 1;
                    end else m_word[i]++;
                end
            end
        end
        @(negedge clk);
    endtask

    function automatic logic rnd_ack();
        return $urandom_range(0, 3) != 0;
    endfunction

    task automatic test_reset();
        for (int k = 0; k < 3; k++) cycle(1'b1, 1'b1);
        n_vec++;
        if ({ifa.we, ifa.sel, ifa.cti, ifa.bte} !== {1'b1, 4'hF, 3'b000, 2'b00}) begin
            n_err++;
            $display("FAIL consts_a got %b want %b", {ifa.we, ifa.sel, ifa.cti, ifa.bte}, {1'b1, 4'hF, 5'b0});
        end
        n_vec++;
        if ({ifb.we, ifb.sel, ifb.cti, ifb.bte} !== {1'b1, 4'hF, 3'b000, 2'b00}) begin
            n_err++;
            $display("FAIL consts_b got %b want %b", {ifb.we, ifb.sel, ifb.cti, ifb.bte}, {1'b1, 4'hF, 5'b0});
        end
        rst_a = 1'b0;
        rst_b = 1'b0;
        #1;
        n_vec++;
        if (ifa.cyc !== 1'b1 || ifa.adr !== 32'h0) begin
            n_err++;
            $display("FAIL first_cycle cyc/adr got %b/%h want 1/00000000", ifa.cyc, ifa.adr);
        end
    endtask

    task automatic test_first_pixels();
        logic [31:0] want_adr [3] = '{32'h0, 32'h4, 32'h8};
        for (int k = 0; k < 3; k++) begin
            #1;
            n_vec++;
            if (ifa.adr !== want_adr[k] || ifa.dat_ms !== 32'h00FF_FFFF) begin
                n_err++;
                $display("FAIL first_pixels[%0d] adr/dat got %h/%h want %h/00ffffff", k, ifa.adr, ifa.dat_ms, want_adr[k]);
            end
            cycle(1'b1, 1'b0);
        end
    endtask

    task automatic test_stall();
        for (int k = 0; k < 5; k++) begin
            #1;
            n_vec++;
            if (ifa.adr !== 32'hC || ifa.dat_ms !== 32'h00FF_FFFF || ifa.cyc !== 1'b1) begin
                n_err++;
                $display("FAIL stall[%0d] adr/dat/cyc got %h/%h/%b want 0000000c/00ffffff/1", k, ifa.adr, ifa.dat_ms, ifa.cyc);
            end
            cycle(1'b0, 1'b0);
        end
        cycle(1'b1, 1'b0);
        #1;
        n_vec++;
        if (ifa.adr !== 32'h10) begin
            n_err++;
            $display("FAIL stall_release adr got %h want 00000010", ifa.adr);
        end
    endtask

    task automatic test_burst_yield();
        int guard = 0;
        while (m_word[0] != 64 && guard < 200) begin
            cycle(1'b1, 1'b0);
            guard++;
        end
        #1;
        n_vec++;
        if (guard >= 200 || ifa.cyc !== !YIELD) begin
            n_err++;
            $display("FAIL burst_yield cyc after 64 acks got %b want %b", ifa.cyc, !YIELD);
        end
        if (YIELD) cycle(1'b1, 1'b0);
        #1;
        n_vec++;
        if (ifa.cyc !== 1'b1 || ifa.adr !== 32'h100) begin
            n_err++;
            $display("FAIL burst_resume cyc/adr got %b/%h want 1/00000100", ifa.cyc, ifa.adr);
        end
    endtask

    task automatic test_grid_pixel();
        int guard = 0;
        while (!(m_word[0] == 17 + 16 * HA && !m_pause[0]) && guard < 40000) begin
            cycle(rnd_ack(), rnd_ack());
            guard++;
        end
        #1;
        n_vec++;
        if (guard >= 40000 || ifa.adr !== 32'h0000_C844 || ifa.dat_ms !== 32'h00FF_FFFF) begin
            n_err++;
            $display("FAIL grid_17_16 adr/dat got %h/%h want 0000c844/00ffffff", ifa.adr, ifa.dat_ms);
        end
    endtask

    task automatic test_frame_wrap();
        int guard = 0;
        while (!(m_word[1] == HB * VB - 1 && !m_pause[1]) && guard < 2000) begin
            cycle(1'b0, 1'b1);
            guard++;
        end
        cycle(1'b0, 1'b1);
        #1;
        n_vec++;
        if (guard >= 2000 || fd_b !== 1'b1 || ifb.cyc !== !YIELD || ifb.adr !== 32'h0) begin
            n_err++;
            $display("FAIL frame_wrap fd/cyc/adr got %b/%b/%h want 1/%b/00000000", fd_b, ifb.cyc, ifb.adr, !YIELD);
        end
        cycle(1'b0, 1'b0);
        #1;
        n_vec++;
        if (fd_b !== 1'b0 || ifb.cyc !== 1'b1 || ifb.adr !== 32'h0) begin
            n_err++;
            $display("FAIL frame_wrap_after fd/cyc/adr got %b/%b/%h want 0/1/00000000", fd_b, ifb.cyc, ifb.adr);
        end
    endtask

    task automatic test_reset_mid();
        int guard = 0;
        rst_a = 1'b1;
        cycle(1'b0, 1'b0);
        rst_a = 1'b0;
        while (!(m_word[0] == 1000 && !m_pause[0]) && guard < 3000) begin
            cycle(1'b1, rnd_ack());
            guard++;
        end
        ifa.ack = 1'b0;
        rst_a = 1'b1;
        #1;
        n_vec++;
        if (guard >= 3000 || ifa.cyc !== 1'b0 || ifa.stb !== 1'b0) begin
            n_err++;
            $display("FAIL reset_mid cyc/stb got %b/%b want 0/0", ifa.cyc, ifa.stb);
        end
        cycle(1'b1, 1'b0);
        cycle(1'b1, 1'b0);
        rst_a = 1'b0;
        #1;
        n_vec++;
        if (ifa.cyc !== 1'b1 || ifa.adr !== 32'h0 || ifa.dat_ms !== 32'h00FF_FFFF) begin
            n_err++;
            $display("FAIL reset_restart cyc/adr/dat got %b/%h/%h want 1/00000000/00ffffff", ifa.cyc, ifa.adr, ifa.dat_ms);
        end
        for (int k = 0; k < 300; k++) cycle(rnd_ack(), rnd_ack());
    endtask

    initial begin
        ifa.ack = 1'b0;
        ifb.ack = 1'b0;
        ifa.dat_sm = $urandom;
        ifb.dat_sm = $urandom;
        for (int i = 0; i < 2; i++) begin
            m_word[i] = 0; m_pause[i] = 0; m_fd[i] = 0;
        end
        @(negedge clk);
        test_reset();
        test_first_pixels();
        test_stall();
        test_burst_yield();
        test_grid_pixel();
        test_frame_wrap();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
